// File: rtl/adc_protect_ctrl.sv
// adc_protect_ctrl: free-running serial ADC reader, voltage limit compare,
// debounced fault/over-temperature inputs and a precharge/main relay
// sequencer with latched trip codes and status LEDs.
// Optional build macro ADC_AVG_EN: volt becomes a 4-sample moving average.
module adc_protect_ctrl #(
  parameter int unsigned ADC_BITS   = 12,
  parameter int unsigned LEAD_BITS  = 4,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned N_FAULT    = 4,
  parameter int unsigned DEB_CYC    = 16,
  parameter int unsigned THR_HI     = 3000,
  parameter int unsigned THR_LO     = 1000,
  parameter int unsigned HYST       = 50,
  parameter int unsigned PRECHG_CYC = 1000,
  parameter int unsigned BLINK_DIV  = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ad_in,
  output logic               adclk,
  output logic               cs_n,
  input  logic               en,
  input  logic               clr,
  input  logic               tem,
  input  logic [N_FAULT-1:0] fault_n,
  output logic               k_1,
  output logic               k_2,
  output logic [15:0]        volt,
  output logic               volt_vld,
  output logic [2:0]         trip_code,
  output logic               led_run,
  output logic               led_trip,
  output logic [N_FAULT-1:0] led_fault
);

  localparam int unsigned FRAME = LEAD_BITS + ADC_BITS;
  localparam int unsigned CW    = $clog2(2 * CLK_DIV);
  localparam int unsigned EW    = $clog2(FRAME + 1);
  localparam int unsigned DW    = $clog2(DEB_CYC);
  localparam int unsigned TW    = $clog2(PRECHG_CYC);
  localparam int unsigned BW    = $clog2(BLINK_DIV);
  localparam int unsigned NI    = N_FAULT + 1;

  localparam logic [CW-1:0] HALF_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(2 * CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_PRE  = EW'(FRAME - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(FRAME);
  localparam logic [DW-1:0] DEB_END   = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] TMO_END   = TW'(PRECHG_CYC - 1);
  localparam logic [BW-1:0] BLINK_END = BW'(BLINK_DIV - 1);
  localparam logic [15:0]   V_HI      = 16'(THR_HI);
  localparam logic [15:0]   V_LO      = 16'(THR_LO);
  localparam logic [15:0]   V_UV      = 16'(THR_LO - HYST);

  typedef enum logic [1:0] {S_IDLE, S_PRECHG, S_RUN, S_TRIP} state_t;

  logic                ad_s1, ad_s2;
  logic [NI-1:0]       in_s1, in_s2, deb;
  logic [NI-1:0][DW-1:0] deb_cnt;
  logic [CW-1:0]       div_cnt;
  logic [EW-1:0]       edge_cnt;
  logic [ADC_BITS-1:0] shreg;
  logic                sample_done;
  logic [15:0]         raw, volt_next;
  logic                flt, ot, ov, uv, ok_lo, tmo;
  logic [TW-1:0]       timer;
  logic [BW-1:0]       blink_cnt;
  state_t              state, state_nx;
  logic [2:0]          code_nx;

  // Two-flop synchronisers; faults are inverted to active-high first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_s1 <= 1'b0; ad_s2 <= 1'b0; in_s1 <= '0; in_s2 <= '0;
    end else begin
      ad_s1 <= ad_in; ad_s2 <= ad_s1;
      in_s1 <= {tem, ~fault_n}; in_s2 <= in_s1;
    end
  end

  // Per-input debounce: a level is accepted after DEB_CYC differing samples in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0; deb_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NI; i++) begin
        if (in_s2[i] == deb[i]) deb_cnt[i] <= '0;
        else if (deb_cnt[i] == DEB_END) begin
          deb[i] <= in_s2[i]; deb_cnt[i] <= '0;
        end else deb_cnt[i] <= deb_cnt[i] + DW'(1);
      end
    end
  end

  assign flt       = |deb[N_FAULT-1:0];
  assign ot        = deb[N_FAULT];
  assign led_fault = deb[N_FAULT-1:0];

  // ADC framing: cs_n gap, then FRAME rising adclk edges sampling ad_in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n <= 1'b1; adclk <= 1'b1; div_cnt <= '0; edge_cnt <= '0;
      shreg <= '0; sample_done <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      if (cs_n) begin
        if (div_cnt == GAP_END) begin
          div_cnt <= '0; edge_cnt <= '0; cs_n <= 1'b0;
        end else div_cnt <= div_cnt + CW'(1);
      end else if (div_cnt == HALF_END) begin
        div_cnt <= '0;
        if (!adclk) begin
          adclk       <= 1'b1;
          edge_cnt    <= edge_cnt + EW'(1);
          shreg       <= {shreg[ADC_BITS-2:0], ad_s2};
          sample_done <= (edge_cnt == EDGE_PRE);
        end else if (edge_cnt == EDGE_LAST) cs_n <= 1'b1;
        else adclk <= 1'b0;
      end else div_cnt <= div_cnt + CW'(1);
    end
  end

  // Zero-extend the finished sample to 16 bits
  always_comb begin
    raw = '0;
    raw[ADC_BITS-1:0] = shreg;
  end

`ifdef ADC_AVG_EN
  logic [15:0] win [3];

  // Window of the three previous samples, shifted on each new sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win[0] <= '0; win[1] <= '0; win[2] <= '0;
    end else if (sample_done) begin
      win[0] <= raw; win[1] <= win[0]; win[2] <= win[1];
    end
  end

  // Truncating mean of the new sample and the window
  always_comb volt_next = 16'((18'(raw) + 18'(win[0]) + 18'(win[1]) + 18'(win[2])) >> 2);
`else
  // Raw sample passes straight through
  always_comb volt_next = raw;
`endif

  // Publish the sample one clock after its last bit was taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      volt <= '0; volt_vld <= 1'b0;
    end else begin
      volt_vld <= sample_done;
      if (sample_done) volt <= volt_next;
    end
  end

  assign ov    = volt_vld && (volt > V_HI);
  assign uv    = volt_vld && (volt < V_UV);
  assign ok_lo = volt_vld && (volt >= V_LO);
  assign tmo   = (timer == TMO_END);

  // State and latched trip code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE; trip_code <= '0;
    end else begin
      state <= state_nx; trip_code <= code_nx;
    end
  end

  // Next state; trip causes are tested in priority order ahead of en=0
  always_comb begin
    state_nx = state;
    code_nx  = trip_code;
    case (state)
      S_IDLE: if (en && !flt && !ot) state_nx = S_PRECHG;
      S_PRECHG, S_RUN: begin
        if (flt) begin
          state_nx = S_TRIP; code_nx = 3'd3;
        end else if (ot) begin
          state_nx = S_TRIP; code_nx = 3'd4;
        end else if (ov) begin
          state_nx = S_TRIP; code_nx = 3'd1;
        end else if (uv && state == S_RUN) begin
          state_nx = S_TRIP; code_nx = 3'd2;
        end else if (tmo && state == S_PRECHG) begin
          state_nx = S_TRIP; code_nx = 3'd5;
        end else if (!en) state_nx = S_IDLE;
        else if (state == S_PRECHG && ok_lo) state_nx = S_RUN;
      end
      S_TRIP: if (clr && !flt && !ot && volt <= V_HI) begin
        state_nx = S_IDLE; code_nx = 3'd0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Precharge timer, cleared outside PRECHG
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= '0;
    else if (state == S_PRECHG) timer <= timer + TW'(1);
    else timer <= '0;
  end

  // Registered relay/LED outputs; blink counter preloads so TRIP lights at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_1 <= 1'b0; k_2 <= 1'b0; led_run <= 1'b0; led_trip <= 1'b0;
      blink_cnt <= BLINK_END;
    end else begin
      k_1     <= (state == S_PRECHG) || (state == S_RUN);
      k_2     <= (state == S_RUN);
      led_run <= (state == S_RUN);
      if (state != S_TRIP) begin
        led_trip <= 1'b0; blink_cnt <= BLINK_END;
      end else if (blink_cnt == BLINK_END) begin
        led_trip <= ~led_trip; blink_cnt <= '0;
      end else blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_adc_protect_ctrl.sv
// Bench for adc_protect_ctrl: ADC serial model feeding a volt scoreboard,
// plus one task per relay/trip scenario.
module tb_adc_protect_ctrl;

  logic        clk = 1'b0, rst = 1'b1, ad_in = 1'b0, en = 1'b0, clr = 1'b0, tem = 1'b0;
  logic [3:0]  fault_n = 4'hF;
  logic        adclk, cs_n, k_1, k_2, volt_vld, led_run, led_trip;
  logic [15:0] volt;
  logic [2:0]  trip_code;
  logic [3:0]  led_fault;

  adc_protect_ctrl #(
    .ADC_BITS(12), .LEAD_BITS(4), .CLK_DIV(2), .N_FAULT(4), .DEB_CYC(16),
    .THR_HI(3000), .THR_LO(1000), .HYST(50), .PRECHG_CYC(1000), .BLINK_DIV(8)
  ) dut (
    .clk(clk), .rst(rst), .ad_in(ad_in), .adclk(adclk), .cs_n(cs_n),
    .en(en), .clr(clr), .tem(tem), .fault_n(fault_n), .k_1(k_1), .k_2(k_2),
    .volt(volt), .volt_vld(volt_vld), .trip_code(trip_code), .led_run(led_run),
    .led_trip(led_trip), .led_fault(led_fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] exp_q[$];
  logic [15:0] frm, exp_v;
  logic [11:0] adc_val = '0;
  int bit_i = 0, frames = 0, vld_cnt = 0, rise_cnt = 0, rise_cyc = 0, gap_len = 0;
  logic gap_ok = 1'b0, prev_adclk = 1'b1, prev_vld = 1'b0, prev_cs = 1'b1;

  // ADC model: garbage lead nibble, then the 12-bit value MSB first
  always @(negedge cs_n) if (rst === 1'b0) begin
    frm = {4'hA, adc_val};
    bit_i = 0;
    ad_in = frm[15];
    exp_q.push_back({4'h0, adc_val});
    frames++;
  end

  always @(posedge adclk) if (rst === 1'b0 && cs_n === 1'b0) begin
    bit_i++;
    if (bit_i < 16) ad_in = frm[15 - bit_i];
  end

  // Scoreboard and framing monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); frames = 0; vld_cnt = 0; rise_cnt = 0; gap_len = 0;
      gap_ok = 1'b0; prev_adclk = 1'b1; prev_vld = 1'b0; prev_cs = 1'b1;
    end else begin
      if (adclk && !prev_adclk && !cs_n) begin
        rise_cnt++;
        if (rise_cnt == 16) rise_cyc = cyc;
      end
      if (prev_vld) begin
        n_vec++;
        if (volt_vld !== 1'b0) begin n_err++; $display("FAIL vld_pulse: vld=%b want 0 on 2nd cycle", volt_vld); end
      end
      if (volt_vld === 1'b1) begin
        vld_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL volt_sb: volt=%h with no expected sample", volt);
        end else begin
          exp_v = exp_q.pop_front();
          if (volt !== exp_v) begin n_err++; $display("FAIL volt_sb: got %h want %h", volt, exp_v); end
        end
        n_vec++;
        if (cyc - rise_cyc !== 1) begin n_err++; $display("FAIL vld_latency: got %0d want 1", cyc - rise_cyc); end
      end
      if (cs_n) gap_len++;
      if (!cs_n && prev_cs) begin
        if (gap_ok) begin
          n_vec++;
          if (gap_len !== 4) begin n_err++; $display("FAIL cs_gap: got %0d want 4", gap_len); end
        end
        gap_ok = 1'b1; gap_len = 0; rise_cnt = 0;
      end
      prev_adclk = adclk; prev_vld = volt_vld; prev_cs = cs_n;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  // Load a sample value and wait until the frame carrying it has been published
  task automatic send(input logic [11:0] v);
    int target, t;
    adc_val = v;
    target = frames + 1;
    t = 0;
    while (vld_cnt < target && t < 400) begin step(); t++; end
    n_vec++;
    if (vld_cnt < target) begin n_err++; $display("FAIL send_timeout: vld_cnt=%0d want %0d", vld_cnt, target); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_vec += 8;
    if (cs_n !== 1'b1)   begin n_err++; $display("FAIL rst_cs_n: got %b want 1", cs_n); end
    if (adclk !== 1'b1)  begin n_err++; $display("FAIL rst_adclk: got %b want 1", adclk); end
    if ({k_1, k_2} !== 2'b00) begin n_err++; $display("FAIL rst_relays: got %b want 00", {k_1, k_2}); end
    if (volt !== 16'h0)  begin n_err++; $display("FAIL rst_volt: got %h want 0000", volt); end
    if (volt_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", volt_vld); end
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL rst_code: got %0d want 0", trip_code); end
    if ({led_run, led_trip} !== 2'b00) begin n_err++; $display("FAIL rst_leds: got %b want 00", {led_run, led_trip}); end
    if (led_fault !== 4'h0) begin n_err++; $display("FAIL rst_led_fault: got %h want 0", led_fault); end
    rst = 1'b0;
  endtask

  task automatic test_adc();
    send(12'hABC);
    send(12'hFFF);
    send(12'h000);
    send(12'h5A3);
  endtask

  task automatic test_start_run();
    send(12'd500);
    en = 1'b1;
    step(2);
    n_vec += 2;
    if (k_1 !== 1'b1) begin n_err++; $display("FAIL prechg_k1: got %b want 1", k_1); end
    if (k_2 !== 1'b0) begin n_err++; $display("FAIL prechg_k2: got %b want 0", k_2); end
    send(12'd500);
    step();
    n_vec++;
    if (k_2 !== 1'b0) begin n_err++; $display("FAIL prechg_500_k2: got %b want 0", k_2); end
    send(12'd1200);
    step();
    n_vec++;
    if (k_2 !== 1'b0) begin n_err++; $display("FAIL run_k2_early: got %b want 0", k_2); end
    step();
    n_vec += 2;
    if ({k_1, k_2} !== 2'b11) begin n_err++; $display("FAIL run_relays: got %b want 11", {k_1, k_2}); end
    if (led_run !== 1'b1) begin n_err++; $display("FAIL run_led: got %b want 1", led_run); end
  endtask

  task automatic test_ov();
    send(12'd3000);
    step(2);
    n_vec++;
    if ({trip_code, k_2} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL ov_3000: code=%0d k_2=%b want 0,1", trip_code, k_2); end
    send(12'd3001);
    step();
    n_vec++;
    if ({trip_code, k_1} !== {3'd1, 1'b1}) begin n_err++; $display("FAIL ov_code: code=%0d k_1=%b want 1,1", trip_code, k_1); end
    step();
    n_vec += 2;
    if ({k_1, k_2, led_run} !== 3'b000) begin n_err++; $display("FAIL ov_relays: got %b want 000", {k_1, k_2, led_run}); end
    if (led_trip !== 1'b1) begin n_err++; $display("FAIL ov_led_trip: got %b want 1", led_trip); end
    pulse_clr();
    step();
    n_vec++;
    if (trip_code !== 3'd1) begin n_err++; $display("FAIL ov_clr_ignored: got %0d want 1", trip_code); end
    en = 1'b0;
    send(12'd2000);
    pulse_clr();
    n_vec++;
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL ov_clr: got %0d want 0", trip_code); end
    step(2);
    n_vec++;
    if (k_1 !== 1'b0) begin n_err++; $display("FAIL ov_idle_k1: got %b want 0", k_1); end
  endtask

  task automatic test_uv();
    en = 1'b1;
    send(12'd1200);
    step(2);
    n_vec++;
    if (k_2 !== 1'b1) begin n_err++; $display("FAIL uv_run: k_2=%b want 1", k_2); end
    send(12'd950);
    step(2);
    n_vec++;
    if ({trip_code, k_2} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL uv_950: code=%0d k_2=%b want 0,1", trip_code, k_2); end
    send(12'd949);
    step();
    n_vec++;
    if (trip_code !== 3'd2) begin n_err++; $display("FAIL uv_code: got %0d want 2", trip_code); end
    en = 1'b0;
    step();
    pulse_clr();
    n_vec++;
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL uv_clr: got %0d want 0", trip_code); end
  endtask

  task automatic test_fault();
    logic [3:0] seen;
    en = 1'b1;
    send(12'd1200);
    step(2);
    fault_n[2] = 1'b0; step(10); fault_n[2] = 1'b1;
    seen = '0;
    for (int i = 0; i < 30; i++) begin step(); seen |= led_fault; end
    n_vec += 2;
    if (seen !== 4'h0) begin n_err++; $display("FAIL glitch_led: got %h want 0", seen); end
    if ({trip_code, k_2} !== {3'd0, 1'b1}) begin n_err++; $display("FAIL glitch_trip: code=%0d k_2=%b want 0,1", trip_code, k_2); end
    fault_n[2] = 1'b0; step(16); fault_n[2] = 1'b1;
    step();
    n_vec++;
    if (led_fault !== 4'h0) begin n_err++; $display("FAIL deb_early: got %h want 0", led_fault); end
    step();
    n_vec++;
    if (led_fault !== 4'h4) begin n_err++; $display("FAIL deb_led: got %h want 4", led_fault); end
    step();
    n_vec++;
    if (trip_code !== 3'd3) begin n_err++; $display("FAIL fault_code: got %0d want 3", trip_code); end
    step(25);
    n_vec++;
    if (led_fault !== 4'h0) begin n_err++; $display("FAIL fault_release: got %h want 0", led_fault); end
    en = 1'b0;
    pulse_clr();
    n_vec++;
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL fault_clr: got %0d want 0", trip_code); end
  endtask

  task automatic test_ot_fault();
    en = 1'b1;
    send(12'd1200);
    step(2);
    tem = 1'b1;
    step(20);
    n_vec++;
    if (trip_code !== 3'd4) begin n_err++; $display("FAIL ot_code: got %0d want 4", trip_code); end
    pulse_clr();
    n_vec++;
    if (trip_code !== 3'd4) begin n_err++; $display("FAIL ot_clr_hot: got %0d want 4", trip_code); end
    tem = 1'b0;
    step(20);
    en = 1'b0;
    pulse_clr();
    n_vec++;
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL ot_clr: got %0d want 0", trip_code); end
    en = 1'b1;
    send(12'd1200);
    step(2);
    fault_n[0] = 1'b0; tem = 1'b1;
    step(20);
    n_vec += 2;
    if (trip_code !== 3'd3) begin n_err++; $display("FAIL prio_code: got %0d want 3", trip_code); end
    if (led_fault !== 4'h1) begin n_err++; $display("FAIL prio_led: got %h want 1", led_fault); end
    fault_n[0] = 1'b1; tem = 1'b0;
    step(20);
    en = 1'b0;
    pulse_clr();
    n_vec++;
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL prio_clr: got %0d want 0", trip_code); end
  endtask

  task automatic test_timeout();
    int t, hi;
    send(12'd500);
    en = 1'b1;
    t = 0;
    while (k_1 !== 1'b1 && t < 10) begin step(); t++; end
    hi = 0;
    while (k_1 === 1'b1 && hi < 1100) begin step(); hi++; end
    n_vec += 3;
    if (hi !== 1000) begin n_err++; $display("FAIL tmo_cycles: got %0d want 1000", hi); end
    if (trip_code !== 3'd5) begin n_err++; $display("FAIL tmo_code: got %0d want 5", trip_code); end
    if (led_trip !== 1'b1) begin n_err++; $display("FAIL blink_on: got %b want 1", led_trip); end
    step(7);
    n_vec++;
    if (led_trip !== 1'b1) begin n_err++; $display("FAIL blink_hold: got %b want 1", led_trip); end
    step();
    n_vec++;
    if (led_trip !== 1'b0) begin n_err++; $display("FAIL blink_toggle: got %b want 0", led_trip); end
    en = 1'b0;
    pulse_clr();
    n_vec++;
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL tmo_clr: got %0d want 0", trip_code); end
  endtask

  task automatic test_reset_midframe();
    int t;
    en = 1'b1;
    send(12'd1200);
    step(2);
    t = 0;
    while (!(cs_n === 1'b0 && adclk === 1'b0) && t < 200) begin step(); t++; end
    #2 rst = 1'b1;
    #1;
    n_vec += 6;
    if ({cs_n, adclk} !== 2'b11) begin n_err++; $display("FAIL mid_rst_adc: got %b want 11", {cs_n, adclk}); end
    if ({k_1, k_2} !== 2'b00) begin n_err++; $display("FAIL mid_rst_relays: got %b want 00", {k_1, k_2}); end
    if (volt !== 16'h0) begin n_err++; $display("FAIL mid_rst_volt: got %h want 0000", volt); end
    if (volt_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_vld: got %b want 0", volt_vld); end
    if (trip_code !== 3'd0) begin n_err++; $display("FAIL mid_rst_code: got %0d want 0", trip_code); end
    if ({led_run, led_trip, led_fault} !== 6'h0) begin n_err++; $display("FAIL mid_rst_leds: got %h want 0", {led_run, led_trip, led_fault}); end
    en = 1'b0;
    step(3);
    rst = 1'b0;
    send(12'h123);
    step(2);
    n_vec++;
    if ({k_1, trip_code} !== 4'h0) begin n_err++; $display("FAIL post_rst_idle: got %h want 0", {k_1, trip_code}); end
  endtask

  initial begin
    test_reset();
    test_adc();
    test_start_run();
    test_ov();
    test_uv();
    test_fault();
    test_ot_fault();
    test_timeout();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, applied=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
